// File: rtl/bram_tile_pkg.sv
// Shared types and default parameters for the bram_tile block.
// Optional write-first bypass is selected by BRAM_TILE_BYPASS_EN (see bram_tile.sv).
package bram_tile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROW_W  = 4;
  localparam int DEF_COL_W  = 4;
  localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/bram_tile_if.sv
// Write/read/clear bus of the bram_tile; master drives strobes, slave is the tile.
interface bram_tile_if
  import bram_tile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ROW_W + DEF_COL_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clr_req;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/bram_tile_array.sv
// Row/column storage array with one write port and a registered read port.
// Neither the array nor the read register is reset; read-during-write is read-first.
module bram_tile_array
  import bram_tile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ROW_W+COL_W-1:0] waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   re,
  input  logic [ROW_W+COL_W-1:0] raddr,
  output logic [DATA_W-1:0]      q
);

  localparam int ADDR_W = ROW_W + COL_W;

  logic [DATA_W-1:0] mem [2**ROW_W][2**COL_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[ADDR_W-1:COL_W]][waddr[COL_W-1:0]] <= wdata;
    if (re) q <= mem[raddr[ADDR_W-1:COL_W]][raddr[COL_W-1:0]];
  end

endmodule

// File: rtl/bram_tile.sv
// BRAM tile: clear FSM, write mux, read pipeline (RD_LAT 1 or 2) around bram_tile_array.
// Define BRAM_TILE_BYPASS_EN for write-first same-address behaviour; default is read-first.
module bram_tile
  import bram_tile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  bram_tile_if.slave  bus
);

  localparam int ADDR_W = ROW_W + COL_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy, wr_acc, rd_acc;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata, arr_q;
  logic              v1;
  logic [DATA_W-1:0] data1, hold;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.clr_req) state_nx = ST_CLEAR;
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                clr_addr <= '0;
    else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  assign busy   = (state == ST_CLEAR);
  assign wr_acc = !busy && bus.wr_en;
  assign rd_acc = !busy && bus.rd_en;

  assign arr_we    = busy || wr_acc;
  assign arr_waddr = busy ? clr_addr : bus.wr_addr;
  assign arr_wdata = busy ? '0 : bus.wr_data;

  bram_tile_array #(
    .DATA_W (DATA_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (rd_acc),
    .raddr (bus.rd_addr),
    .q     (arr_q)
  );

  // Not gated by busy so a read accepted alongside clr_req still drains.
  always_ff @(posedge clk) begin
    if (!rst_n) v1 <= 1'b0;
    else        v1 <= rd_acc;
  end

`ifdef BRAM_TILE_BYPASS_EN
  logic              byp;
  logic [DATA_W-1:0] byp_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp      <= 1'b0;
      byp_data <= '0;
    end else if (rd_acc) begin
      byp      <= wr_acc && (bus.wr_addr == bus.rd_addr);
      byp_data <= bus.wr_data;
    end
  end

  assign data1 = byp ? byp_data : arr_q;
`else
  assign data1 = arr_q;
`endif

  // hold gives rd_data its reset value and keeps it stable between reads.
  always_ff @(posedge clk) begin
    if (!rst_n)  hold <= '0;
    else if (v1) hold <= data1;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic v2;
      always_ff @(posedge clk) begin
        if (!rst_n) v2 <= 1'b0;
        else        v2 <= v1;
      end
      assign bus.rd_valid = v2;
      assign bus.rd_data  = hold;
    end else begin : g_lat1
      assign bus.rd_valid = v1;
      assign bus.rd_data  = v1 ? data1 : hold;
    end
  endgenerate

  assign bus.busy = busy;

endmodule
